// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch/decode boundary: reset values, opcode and
// funct codes, and the immediate-extender mode encodings.
package if_id_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    typedef enum logic [1:0] {
        EXTOP_SIGN  = 2'b00,
        EXTOP_ZERO  = 2'b01,
        EXTOP_SHAMT = 2'b10
    } extop_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch/decode register stage and its neighbours
// (hazard unit, branch resolution, instruction memory, decoder).
interface if_id_stage_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [15:0] id_imm16;
    logic [4:0]  id_shamt;
    logic [1:0]  id_extop;
    logic [31:0] fetch_cnt;

    modport master (
        output stall, flush, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, id_instr, id_pc4, id_valid, id_imm16, id_shamt,
               id_extop, fetch_cnt
    );

    modport slave (
        input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, id_instr, id_pc4, id_valid, id_imm16, id_shamt,
               id_extop, fetch_cnt
    );
endinterface

// File: rtl/if_id_stage_pc_reg.sv
// Program counter: reset load, redirect load, hazard hold, else +4.
// Flush does not touch the PC; only stall can hold it.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [29:0] i_redirect_word,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);
    logic [31:0] r_pc;

    // Carry out of bit 31 is dropped, so the PC wraps modulo 2^32.
    assign o_pc_plus4 = r_pc + 32'd4;
    assign o_pc       = r_pc;

    // PC update with reset > redirect > stall > advance priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else if (i_redirect_valid) begin
            r_pc <= {i_redirect_word, 2'b00};
        end else if (!i_stall) begin
            r_pc <= o_pc_plus4;
        end
    end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: owns the PC sub-block, the ID-stage instruction
// register, the accepted-fetch counter and the immediate-extender mode decode.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = if_id_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_id_stage_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    if_id_stage_if.slave bus
);
    import if_id_stage_pkg::*;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    extop_e      w_extop;

    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_fetch_cnt;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk              (clk),
        .rst              (rst),
        .i_stall          (bus.stall),
        .i_redirect_valid (bus.redirect_valid),
        .i_redirect_word  (bus.redirect_pc[31:2]),
        .o_pc             (w_pc),
        .o_pc_plus4       (w_pc_plus4)
    );

    // ID-stage register: bubbles on redirect/flush carry pc4 = 0 so a
    // squashed slot never looks like a real return address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr  <= NOP_INSTR;
            r_id_pc4    <= 32'd0;
            r_id_valid  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else if (bus.redirect_valid || bus.flush) begin
            r_id_instr  <= NOP_INSTR;
            r_id_pc4    <= 32'd0;
            r_id_valid  <= 1'b0;
        end else if (!bus.stall) begin
            r_id_instr  <= bus.imem_rdata;
            r_id_pc4    <= w_pc_plus4;
            r_id_valid  <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign w_opcode = r_id_instr[31:26];
    assign w_funct  = r_id_instr[5:0];

    // Extender mode: logical immediates zero-extend, shifts by constant use
    // shamt, everything else sign-extends. Encoding 2'b11 is unreachable.
    always_comb begin
        w_extop = EXTOP_SIGN;
        case (w_opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_extop = EXTOP_ZERO;
            OP_SPECIAL: begin
                if (w_funct == FN_SLL || w_funct == FN_SRL || w_funct == FN_SRA)
                    w_extop = EXTOP_SHAMT;
            end
            default: w_extop = EXTOP_SIGN;
        endcase
    end

    assign bus.imem_addr = w_pc;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc4    = r_id_pc4;
    assign bus.id_valid  = r_id_valid;
    assign bus.fetch_cnt = r_fetch_cnt;
    assign bus.id_imm16  = r_id_instr[15:0];
    assign bus.id_shamt  = r_id_instr[10:6];
    assign bus.id_extop  = w_extop;
endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage against a cycle-level behavioural model,
// with directed scenarios for reset, stall, redirect, flush, decode and wrap.
module tb_if_id_stage;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    if_id_stage_if bus ();

    if_id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction memory: fixed word at the reset vector, hash elsewhere,
    // or a forced word when the bench wants a specific opcode in flight.
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_word = 32'h0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (ovr_en) return ovr_word;
        if (a == 32'h0000_3000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb bus.imem_rdata = imem_word(bus.imem_addr);

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    function automatic logic [1:0] ref_extop(input logic [31:0] w);
        int op, fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (op >= 12 && op <= 15) return 2'b01;
        if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare #1 later.
    task automatic cycle(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] rp);
        logic [31:0] fetched;
        rst = r; bus.stall = s; bus.flush = f;
        bus.redirect_valid = rv; bus.redirect_pc = rp;
        @(posedge clk);
        fetched = imem_word(m_pc);
        if (r) begin
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (rv) begin
            m_pc = rp & ~32'd3; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (f) begin
            m_instr = NOP; m_pc4 = 0; m_valid = 0;
            if (!s) m_pc = m_pc + 4;
        end else if (!s) begin
            m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1;
            m_cnt = m_cnt + 1; m_pc = m_pc + 4;
        end
        #1;
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("id_instr", bus.id_instr, m_instr);
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
        chk("fetch_cnt", bus.fetch_cnt, m_cnt);
        if (!f || r || rv) chk("id_pc4", bus.id_pc4, m_pc4);
        chk("id_extop", {30'd0, bus.id_extop}, {30'd0, ref_extop(m_instr)});
        chk("id_imm16", {16'd0, bus.id_imm16}, {16'd0, m_instr[15:0]});
        chk("id_shamt", {27'd0, bus.id_shamt}, {27'd0, m_instr[10:6]});
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23};
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h20};
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;

        // Reset held two cycles, then first fetch from the reset vector.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 32'h1234_5678);
        chk("rst_addr", bus.imem_addr, 32'h0000_3000);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("first_instr", bus.id_instr, 32'h2008_0005);
        chk("first_pc4", bus.id_pc4, 32'h0000_3004);
        chk("first_cnt", bus.fetch_cnt, 32'd1);

        // Stall after two fetches, then release.
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("stall_addr", bus.imem_addr, 32'h0000_3008);
            chk("stall_cnt", bus.fetch_cnt, 32'd2);
        end
        cycle(0, 0, 0, 0, 0);
        chk("release_addr", bus.imem_addr, 32'h0000_300C);

        // Redirect wins over stall; low address bits are dropped.
        cycle(0, 1, 0, 1, 32'h0000_4003);
        chk("redir_addr", bus.imem_addr, 32'h0000_4000);
        chk("redir_instr", bus.id_instr, NOP);
        chk("redir_cnt", bus.fetch_cnt, 32'd3);

        // Flush with and without stall.
        cycle(0, 1, 1, 0, 0);
        chk("flush_stall_addr", bus.imem_addr, 32'h0000_4000);
        cycle(0, 0, 1, 0, 0);
        chk("flush_adv_addr", bus.imem_addr, 32'h0000_4004);

        // Extender decode.
        ovr_en = 1; ovr_word = 32'h3C01_1234;
        cycle(0, 0, 0, 0, 0);
        chk("lui_extop", {30'd0, bus.id_extop}, 32'd1);
        chk("lui_imm", {16'd0, bus.id_imm16}, 32'h1234);
        ovr_word = 32'h0001_0880;
        cycle(0, 0, 0, 0, 0);
        chk("sll_extop", {30'd0, bus.id_extop}, 32'd2);
        chk("sll_shamt", {27'd0, bus.id_shamt}, 32'd2);
        ovr_word = 32'h2001_FFFF;
        cycle(0, 0, 0, 0, 0);
        chk("addi_extop", {30'd0, bus.id_extop}, 32'd0);
        ovr_en = 0;

        // PC wrap.
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        chk("wrap_pc4", bus.id_pc4, 32'h0000_0000);

        // Reset in the middle of a stall.
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("midstall_rst_cnt", bus.fetch_cnt, 32'd0);
        chk("midstall_rst_addr", bus.imem_addr, RST_PC);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rp;
            ovr_en = ($urandom_range(0, 1) == 1);
            ovr_word = {ops[$urandom_range(0, 6)], 20'($urandom), fns[$urandom_range(0, 4)]};
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
